// File: rtl/uart_tx_sequencer.sv
// UART TX frame controller driving an external LSB-first shift register.
// Optional even parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  sr_ld,
    output logic [DATA_WIDTH-1:0] sr_par_in,
    output logic                  sr_shift,
    output logic                  sr_ser_in,
    input  logic                  sr_ser_out,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    logic parity_r;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t              state_r;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic                baud_end_s;

    assign baud_end_s = (baud_cnt_r == BAUD_LAST);
    assign sr_par_in  = in_data;
    assign sr_ser_in  = 1'b1;

    // Frame sequencing: state, baud and bit counters advance at bit-period ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    if (in_valid) begin
                        state_r  <= START;
`ifdef UART_TX_PARITY_EN
                        parity_r <= even_parity(in_data);
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
                            state_r   <= PARITY;
`else
                            state_r   <= STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                        state_r    <= STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r <= '0;
                            state_r   <= IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                end
            endcase
        end
    end

    // Output decode from registered state; only tx in DATA follows sr_ser_out.
    always_comb begin
        tx       = 1'b1;
        in_ready = 1'b0;
        sr_ld    = 1'b0;
        sr_shift = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                sr_ld    = in_valid & ~rst;
            end
            START: begin
                tx = 1'b0;
            end
            DATA: begin
                tx       = sr_ser_out;
                sr_shift = baud_end_s;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_r;
            end
`endif
            STOP: begin
                tx   = 1'b1;
                done = baud_end_s & (bit_cnt_r == STOP_LAST);
            end
            default: begin
                tx   = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: table of frames plus reset and two-stop-bit sequences,
// with a behavioural shift register and a queue of expected line bits.
module tb_uart_tx_sequencer;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = 8'h00;
    logic          sel = 1'b0;

    logic          in_ready1, sr_ld1, sr_shift1, sr_ser_in1, tx1, busy1, done1;
    logic [DW-1:0] sr_par_in1;
    logic [DW-1:0] sr1 = 8'h00;
    logic          in_ready2, sr_ld2, sr_shift2, sr_ser_in2, tx2, busy2, done2;
    logic [DW-1:0] sr_par_in2;
    logic [DW-1:0] sr2 = 8'h00;

    logic          o_tx, o_ready, o_ld, o_shift, o_busy, o_done;
    logic [DW-1:0] o_par;

    int total = 0;
    int passed = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_sequencer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .sr_ld(sr_ld1), .sr_par_in(sr_par_in1),
        .sr_shift(sr_shift1), .sr_ser_in(sr_ser_in1), .sr_ser_out(sr1[0]),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    uart_tx_sequencer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .sr_ld(sr_ld2), .sr_par_in(sr_par_in2),
        .sr_shift(sr_shift2), .sr_ser_in(sr_ser_in2), .sr_ser_out(sr2[0]),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    // External right-shift registers, LSB out first.
    always @(posedge clk) begin
        if (sr_ld1) sr1 <= sr_par_in1;
        else if (sr_shift1) sr1 <= {sr_ser_in1, sr1[DW-1:1]};
        if (sr_ld2) sr2 <= sr_par_in2;
        else if (sr_shift2) sr2 <= {sr_ser_in2, sr2[DW-1:1]};
    end

    assign o_tx    = sel ? tx2 : tx1;
    assign o_ready = sel ? in_ready2 : in_ready1;
    assign o_ld    = sel ? sr_ld2 : sr_ld1;
    assign o_shift = sel ? sr_shift2 : sr_shift1;
    assign o_busy  = sel ? busy2 : busy1;
    assign o_done  = sel ? done2 : done1;
    assign o_par   = sel ? sr_par_in2 : sr_par_in1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic idle_check();
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_tx", o_tx, 1);
        check("idle_ready", o_ready, 1);
        check("idle_busy", o_busy, 0);
        check("idle_done", o_done, 0);
        check("idle_shift", o_shift, 0);
        check("idle_ld", o_ld, 0);
        @(posedge clk); #1;
    endtask

    // mode 0: in_valid low during frame, 1: random valid/data, 2: valid held high.
    task automatic run_frame(input logic [DW-1:0] d, input int mode, input logic exp_par);
        int stops;
        int f;
        int shifts;
        logic exp_bit;
        stops  = sel ? 2 : 1;
        f      = (1 + DW + P + stops) * CPB;
        shifts = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (P == 1) exp_q.push_back(exp_par);
        for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        check("accept_ready", o_ready, 1);
        check("accept_ld", o_ld, 1);
        check("accept_par_in", o_par, d);
        @(posedge clk); #1;
        for (int c = 1; c <= f; c++) begin
            case (mode)
                1: begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = 8'($urandom_range(0, 255));
                end
                2: in_valid = 1'b1;
                default: in_valid = 1'b0;
            endcase
            @(negedge clk);
            if ((c - 1) % CPB == CPB / 2) begin
                exp_bit = exp_q.pop_front();
                check("tx_bit", o_tx, exp_bit);
            end
            check("sr_shift", o_shift, (c % CPB == 0) && (c >= 2 * CPB) && (c <= (1 + DW) * CPB));
            if (o_shift) shifts++;
            check("done", o_done, c == f);
            check("busy", o_busy, 1);
            check("ready_low", o_ready, 0);
            check("no_ld_busy", o_ld, 0);
            @(posedge clk); #1;
        end
        check("shift_count", shifts, DW);
        if (mode != 2) in_valid = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            mode;
        logic          gap;
        logic          exp_par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'hA5, mode: 0, gap: 1'b1, exp_par: 1'b0};
        vecs[1] = '{data: 8'h07, mode: 0, gap: 1'b1, exp_par: 1'b1};
        vecs[2] = '{data: 8'h03, mode: 0, gap: 1'b1, exp_par: 1'b0};
        vecs[3] = '{data: 8'h00, mode: 2, gap: 1'b1, exp_par: 1'b0};
        vecs[4] = '{data: 8'hFF, mode: 0, gap: 1'b0, exp_par: 1'b0};
        vecs[5] = '{data: 8'h6B, mode: 1, gap: 1'b1, exp_par: 1'b1};

        // Reset with in_valid high: no load strobe may escape.
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_ld_forced", o_ld, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_check();

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].gap) idle_check();
            run_frame(vecs[v].data, vecs[v].mode, vecs[v].exp_par);
        end
        idle_check();

        // Reset in the middle of data bit 3.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        check("mid_accept", o_ld, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_busy_before", o_busy, 1);
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        check("mid_rst_ld", o_ld, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_tx", o_tx, 1);
        check("mid_busy", o_busy, 0);
        check("mid_ready", o_ready, 1);
        for (int c = 0; c < 2 * CPB; c++) begin
            @(negedge clk);
            check("mid_no_shift", o_shift, 0);
        end
        @(posedge clk); #1;
        run_frame(8'h3C, 0, 1'b0);
        idle_check();

        // Two stop bits on the second instance.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sel = 1'b1;
        idle_check();
        run_frame(8'h81, 0, 1'b0);
        idle_check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
